// File: rtl/lap_ctl.sv
// lap_ctl: stopwatch control FSM with a prescaled time counter and a lap-capture buffer
//   Optional feature macro: LAP_CTL_SATURATE_EN (count saturates at all-ones instead of wrapping)
//   clk, reset (async, active-high), trig (start/pause/resume), split (lap / clear),
//   lap_sel (lap read index) -> init_regs, count_enabled (Mealy control pair),
//   count, lap_time, lap_count, lap_full, overflow
module lap_ctl #(
  parameter int CNT_W    = 16,
  parameter int LAPS     = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trig,
  input  logic                    split,
  input  logic [$clog2(LAPS)-1:0] lap_sel,
  output logic                    init_regs,
  output logic                    count_enabled,
  output logic [CNT_W-1:0]        count,
  output logic [CNT_W-1:0]        lap_time,
  output logic [$clog2(LAPS):0]   lap_count,
  output logic                    lap_full,
  output logic                    overflow
);
  localparam int SW = $clog2(LAPS);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, COUNTING, PAUSED} state_t;
  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW:0]      lap_cnt_q, lap_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] lap_mem [LAPS];
  logic             tick, at_max, cap;
  // reset also drives the Mealy pair so init_regs reacts without a clock edge
  always_comb begin
    state_d       = state_q;
    init_regs     = reset;
    count_enabled = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          init_regs     = !trig;
          count_enabled = trig;
          state_d       = trig ? COUNTING : IDLE;
        end
        COUNTING: begin
          count_enabled = !trig;
          state_d       = trig ? PAUSED : COUNTING;
        end
        PAUSED: begin
          count_enabled = trig;
          state_d       = trig ? COUNTING : split ? IDLE : PAUSED;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // the capture uses count_q, i.e. the value before any increment on the same edge
  always_comb begin
    tick   = count_enabled && (pre_q == PW'(TICK_DIV - 1));
    at_max = &count_q;
    cap    = (state_q == COUNTING) && !trig && split && !lap_full;
`ifdef LAP_CTL_SATURATE_EN
    count_d = init_regs ? '0 : (tick && !at_max) ? count_q + 1'b1 : count_q;
`else
    count_d = init_regs ? '0 : tick ? count_q + 1'b1 : count_q;
`endif
    ovf_d     = init_regs ? 1'b0 : ovf_q | (tick & at_max);
    pre_d     = init_regs ? '0 : !count_enabled ? pre_q : tick ? '0 : pre_q + 1'b1;
    lap_cnt_d = init_regs ? '0 : cap ? lap_cnt_q + 1'b1 : lap_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      count_q   <= '0;
      lap_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      lap_cnt_q <= lap_cnt_d;
      ovf_q     <= ovf_d;
    end
  end
  // lap storage is never cleared; entries at or beyond lap_count are masked on read
  always_ff @(posedge clk) begin
    if (cap) lap_mem[lap_cnt_q[SW-1:0]] <= count_q;
  end
  assign count     = count_q;
  assign lap_count = lap_cnt_q;
  assign lap_full  = lap_cnt_q == (SW + 1)'(LAPS);
  assign overflow  = ovf_q;
  assign lap_time  = ({1'b0, lap_sel} < lap_cnt_q) ? lap_mem[lap_sel] : '0;
endmodule
